conv1d_tap_loader: RTL and testbench

Write-side counterpart of the conv1d 5:1 tap-select mux. It accepts a serial stream of samples over a valid/ready handshake and distributes each sample into one of five tap registers, using the same 3-bit select encoding as the mux (4→tap1, 3→tap2, 2→tap3, 1→tap4, 0→tap5). When all five taps are loaded, it presents the window to the conv1d datapath with a second valid/ready handshake. It sits between the sample input FIFO and the tap mux/MAC.

---
 rtl/conv1d_pkg.sv | 20 ++
 rtl/conv1d_tap_loader_if.sv | 29 ++
 rtl/conv1d_sel_counter.sv | 37 +++
 rtl/conv1d_tap_loader.sv | 116 +++++++++++
 tb/tb_conv1d_tap_loader.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/conv1d_pkg.sv
// Shared conv1d definitions: tap count, 3-bit tap-select encoding and loader states.
package conv1d_pkg;

  localparam int NUM_TAPS = 5;

  localparam logic [2:0] TAP_SEL_FIRST = 3'd4;
  localparam logic [2:0] TAP_SEL_LAST  = 3'd0;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FULL  = 2'd1,
    SLIDE = 2'd2
  } loader_state_e;

  // Select code addressing 0-based tap index i (tap1 is index 0 and uses code 4).
  function automatic logic [2:0] sel_for_tap(input int i);
    return 3'(NUM_TAPS - 1 - i);
  endfunction

endpackage

// File: rtl/conv1d_tap_loader_if.sv
// Sample-in / window-out handshake bundle of the conv1d tap loader.
interface conv1d_tap_loader_if #(
  parameter int WIDTH = 8
) ();

  logic             clear_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] tap1_o;
  logic [WIDTH-1:0] tap2_o;
  logic [WIDTH-1:0] tap3_o;
  logic [WIDTH-1:0] tap4_o;
  logic [WIDTH-1:0] tap5_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [2:0]       sel_o;

  modport master (
    output clear_i, in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, tap1_o, tap2_o, tap3_o, tap4_o, tap5_o, out_valid_o, sel_o
  );

  modport slave (
    input  clear_i, in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, tap1_o, tap2_o, tap3_o, tap4_o, tap5_o, out_valid_o, sel_o
  );

endinterface

// File: rtl/conv1d_sel_counter.sv
// 3-bit tap-select down-counter: 4 -> 0, reloadable to 4, saturating at the last tap.
module conv1d_sel_counter
  import conv1d_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       dec_i,
  output logic [2:0] sel_o,
  output logic       is_last_o
);

  logic [2:0] sel_q;
  logic [2:0] sel_d;

  // Holding at the last code keeps 5..7 unreachable and leaves tap5 addressed for sliding.
  always_comb begin
    sel_d = sel_q;
    if (load_i) begin
      sel_d = TAP_SEL_FIRST;
    end else if (dec_i && !is_last_o) begin
      sel_d = sel_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q <= TAP_SEL_FIRST;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel_o     = sel_q;
  assign is_last_o = (sel_q == TAP_SEL_LAST);

endmodule

// File: rtl/conv1d_tap_loader.sv
// Serial-to-window loader feeding the conv1d tap mux; define CONV1D_LOADER_SLIDE_EN
// for a stride-1 sliding window instead of non-overlapping 5-sample windows.
module conv1d_tap_loader
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  conv1d_tap_loader_if.slave bus
);

  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_FULL  = FULL;
  localparam logic [1:0] ST_SLIDE = SLIDE;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] tap_q [NUM_TAPS];
  logic [WIDTH-1:0] tap_d [NUM_TAPS];
  logic [2:0]       sel;
  logic             sel_last;
  logic             sel_load;
  logic             sel_dec;
  logic             accept;

  conv1d_sel_counter u_sel (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (sel_load),
    .dec_i     (sel_dec),
    .sel_o     (sel),
    .is_last_o (sel_last)
  );

  assign bus.in_ready_o = !rst_i && !bus.clear_i && (state_q == ST_LOAD || state_q == ST_SLIDE);
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    sel_load = 1'b0;
    sel_dec  = 1'b0;
    if (bus.clear_i) begin
      state_d  = ST_LOAD;
      sel_load = 1'b1;
      for (int i = 0; i < NUM_TAPS; i++) begin
        tap_d[i] = '0;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
              if (sel == sel_for_tap(i)) begin
                tap_d[i] = bus.in_data_i;
              end
            end
            if (sel_last) begin
              state_d = ST_FULL;
            end else begin
              sel_dec = 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (bus.out_ready_i) begin
`ifdef CONV1D_LOADER_SLIDE_EN
            // Select stays on tap5, so the next beat completes the shifted window.
            state_d = ST_SLIDE;
            for (int i = 0; i < NUM_TAPS - 1; i++) begin
              tap_d[i] = tap_q[i + 1];
            end
`else
            state_d  = ST_LOAD;
            sel_load = 1'b1;
`endif
          end
        end
`ifdef CONV1D_LOADER_SLIDE_EN
        ST_SLIDE: begin
          if (accept) begin
            tap_d[NUM_TAPS - 1] = bus.in_data_i;
            state_d             = ST_FULL;
          end
        end
`endif
        default: begin
          state_d  = ST_LOAD;
          sel_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOAD;
      for (int i = 0; i < NUM_TAPS; i++) begin
        tap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  assign bus.tap1_o      = tap_q[0];
  assign bus.tap2_o      = tap_q[1];
  assign bus.tap3_o      = tap_q[2];
  assign bus.tap4_o      = tap_q[3];
  assign bus.tap5_o      = tap_q[4];
  assign bus.out_valid_o = (state_q == ST_FULL);
  assign bus.sel_o       = sel;

endmodule

// File: tb/tb_conv1d_tap_loader.sv
// Self-checking bench for conv1d_tap_loader: window model plus directed and random stimulus.
module tb_conv1d_tap_loader;
  import conv1d_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  always #5 clk = ~clk;

  conv1d_tap_loader_if #(.WIDTH(8)) bus ();

  conv1d_tap_loader #(.WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Reference: a window of up to five held samples and a "presented" flag.
  int         mCnt;
  logic [7:0] mWin [5];
  bit         mFull;

  always @(posedge clk) begin : refModel
    int         c;
    logic [7:0] w [5];
    bit         f;
    c = mCnt;
    w = mWin;
    f = mFull;
    if (rst || bus.clear_i) begin
      c = 0;
      f = 0;
      foreach (w[i]) w[i] = 8'h00;
    end else if (!f) begin
      if (bus.in_valid_i) begin
        w[c] = bus.in_data_i;
        c++;
        if (c == 5) f = 1;
      end
    end else if (bus.out_ready_i) begin
      f = 0;
`ifdef CONV1D_LOADER_SLIDE_EN
      for (int i = 0; i < 4; i++) w[i] = w[i + 1];
      c = 4;
`else
      c = 0;
`endif
    end
    mCnt  <= c;
    mWin  <= w;
    mFull <= f;
    cycle <= cycle + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  task automatic checkOutput();
    chk("in_ready", 32'(bus.in_ready_o), 32'(!rst && !bus.clear_i && !mFull));
    chk("out_valid", 32'(bus.out_valid_o), 32'(mFull));
    chk("sel", 32'(bus.sel_o), mFull ? 32'd0 : 32'(4 - mCnt));
    chk("tap1", 32'(bus.tap1_o), 32'(mWin[0]));
    chk("tap2", 32'(bus.tap2_o), 32'(mWin[1]));
    chk("tap3", 32'(bus.tap3_o), 32'(mWin[2]));
    chk("tap4", 32'(bus.tap4_o), 32'(mWin[3]));
    chk("tap5", 32'(bus.tap5_o), 32'(mWin[4]));
  endtask

  // Checks the outputs of the edge just taken, then drives the next cycle's inputs.
  task automatic applyStimulus(input logic r, input logic clr, input logic v,
                               input logic [7:0] d, input logic ordy);
    @(negedge clk);
    checkOutput();
    rst             = r;
    bus.clear_i     = clr;
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.out_ready_i = ordy;
  endtask

  task automatic expectWindow(input string nm, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
    chk({nm, "_tap1"}, 32'(bus.tap1_o), 32'(e1));
    chk({nm, "_tap2"}, 32'(bus.tap2_o), 32'(e2));
    chk({nm, "_tap3"}, 32'(bus.tap3_o), 32'(e3));
    chk({nm, "_tap4"}, 32'(bus.tap4_o), 32'(e4));
    chk({nm, "_tap5"}, 32'(bus.tap5_o), 32'(e5));
  endtask

  task automatic feedFive(input logic [7:0] base, input logic ordy);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 8'(base * (i + 1)), ordy);
  endtask

  initial begin
    rst             = 1'b1;
    bus.clear_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 8'h00;
    bus.out_ready_i = 1'b0;
    @(posedge clk);

    // Reset state, then back-to-back window with the consumer always ready
    applyStimulus(0, 0, 0, 8'h00, 1);
    chk("reset_in_ready", 32'(bus.in_ready_o), 32'd0);
    chk("reset_sel", 32'(bus.sel_o), 32'd4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 8'(8'h11 * (i + 1)), 1);
      chk("sel_step", 32'(bus.sel_o), 32'(4 - i));
    end
    applyStimulus(0, 0, 0, 8'h00, 1);
    chk("t1_valid", 32'(bus.out_valid_o), 32'd1);
    expectWindow("t1", 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    applyStimulus(0, 0, 0, 8'h00, 1);
    chk("t1_valid_drop", 32'(bus.out_valid_o), 32'd0);
`ifndef CONV1D_LOADER_SLIDE_EN
    chk("t1_sel_reload", 32'(bus.sel_o), 32'd4);
`endif

    // Backpressure: window held while extra beats are offered
    applyStimulus(1, 0, 0, 8'h00, 0);
    feedFive(8'h11, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, 8'($urandom), 0);
      chk("bp_valid", 32'(bus.out_valid_o), 32'd1);
      chk("bp_tap3", 32'(bus.tap3_o), 32'h33);
    end
    applyStimulus(0, 0, 0, 8'h00, 1);

    // Valid on alternate cycles gives the same window
    applyStimulus(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, (i % 2) == 0, ((i % 2) == 0) ? 8'(8'h11 * (i / 2 + 1)) : 8'hEE, 0);
    end
    applyStimulus(0, 0, 0, 8'h00, 0);
    expectWindow("gap", 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    applyStimulus(0, 0, 0, 8'h00, 1);

    // Clear mid-window with a beat offered in the same cycle
    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'hA1, 0);
    applyStimulus(0, 0, 1, 8'hA2, 0);
    applyStimulus(0, 0, 1, 8'hA3, 0);
    applyStimulus(0, 1, 1, 8'hFF, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    chk("clr_sel", 32'(bus.sel_o), 32'd4);
    expectWindow("clr", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 8'(8'h61 + i), 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    expectWindow("post_clr", 8'h61, 8'h62, 8'h63, 8'h64, 8'h65);
    applyStimulus(0, 0, 0, 8'h00, 1);

    // Reset after four beats discards the partial window
    applyStimulus(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 8'(8'h81 + i), 0);
    applyStimulus(1, 0, 1, 8'h99, 1);
    applyStimulus(0, 0, 0, 8'h00, 0);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
    chk("rst_sel", 32'(bus.sel_o), 32'd4);
    chk("rst_tap1", 32'(bus.tap1_o), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 8'(8'h71 + i), 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    expectWindow("post_rst", 8'h71, 8'h72, 8'h73, 8'h74, 8'h75);
    applyStimulus(0, 0, 0, 8'h00, 1);

`ifdef CONV1D_LOADER_SLIDE_EN
    // Sliding windows over 1..7, two cycles apart
    begin
      int idx = 1;
      int wins = 0;
      int lastCyc = 0;
      applyStimulus(1, 0, 0, 8'h00, 1);
      for (int n = 0; n < 20; n++) begin
        applyStimulus(0, 0, idx <= 7, (idx <= 7) ? 8'(idx) : 8'h00, 1);
        if (bus.out_valid_o) begin
          expectWindow("slide", 8'(wins + 1), 8'(wins + 2), 8'(wins + 3), 8'(wins + 4), 8'(wins + 5));
          if (wins > 0) chk("slide_spacing", 32'(cycle - lastCyc), 32'd2);
          lastCyc = cycle;
          wins++;
        end
        if (idx <= 7 && !mFull) idx++;
      end
      chk("slide_windows", 32'(wins), 32'd3);
    end
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6);
    end
    applyStimulus(0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
